mem_stage: RTL and testbench

- Memory-access (MEM) stage of the 5-stage LoongArch pipeline, between EX and WB.
- Accepts the EX result bus and waits for the data-SRAM response on loads.
- Performs byte/half/word extraction with sign or zero extension, then hands {rf_we, dest, pc, final_result} to WB through the valid/allow_in handshake.
- Also publishes a hazard/forwarding bus so ID can detect load-use stalls.

---
 rtl/mem_stage_pkg.sv | 47 ++++
 rtl/mem_stage_if.sv | 27 ++
 rtl/mem_stage_load_align.sv | 25 ++
 rtl/mem_stage.sv | 87 ++++++++
 tb/tb_mem_stage.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, load encodings and bus payload layouts for the MEM stage.
package mem_stage_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned REG_WD       = 5;
   localparam int unsigned LT_WD        = 3;
   localparam int unsigned ES_TO_MS_WD  = 74;
   localparam int unsigned MS_TO_WS_WD  = 70;
   localparam int unsigned MS_TO_CHE_WD = 7;

   typedef enum logic [LT_WD-1:0] {
      LD_W  = 3'd0,
      LD_B  = 3'd1,
      LD_H  = 3'd2,
      LD_BU = 3'd4,
      LD_HU = 3'd5
   } load_type_e;

   // Field order matches the packed bus layout, MSB first.
   typedef struct packed {
      logic              res_from_mem;
      load_type_e        load_type;
      logic              rf_we;
      logic [REG_WD-1:0] dest;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   alu_result;
   } es_to_ms_t;

   typedef struct packed {
      logic              rf_we;
      logic [REG_WD-1:0] dest;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   final_result;
   } ms_to_ws_t;

   typedef struct packed {
      logic              load_pending;
      logic              rf_we;
      logic [REG_WD-1:0] dest;
   } ms_to_che_t;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_HAVE = 1'b1
   } dstate_e;

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM, MEM->WB, data-SRAM response and hazard signals seen by the MEM stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic            es_to_ms_valid;
   es_to_ms_t       es_to_ms_bus;
   logic            ms_allow_in;
   logic            ws_allow_in;
   logic            ms_to_ws_valid;
   ms_to_ws_t       ms_to_ws_bus;
   logic            data_sram_data_ok;
   logic [XLEN-1:0] data_sram_rdata;
   ms_to_che_t      ms_to_che_bus;

   modport slave (
      input  es_to_ms_valid, es_to_ms_bus, ws_allow_in,
             data_sram_data_ok, data_sram_rdata,
      output ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_che_bus
   );

   modport master (
      output es_to_ms_valid, es_to_ms_bus, ws_allow_in,
             data_sram_data_ok, data_sram_rdata,
      input  ms_allow_in, ms_to_ws_valid, ms_to_ws_bus, ms_to_che_bus
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data extraction: shift to the addressed byte lane, then sign/zero extend.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [XLEN-1:0] raw,
   input  logic [1:0]      addr,
   input  load_type_e      load_type,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = raw >> {addr, 3'b000};
      result  = raw;
      case (load_type)
         LD_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         LD_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         LD_BU:   result = {24'd0, shifted[7:0]};
         LD_HU:   result = {16'd0, shifted[15:0]};
         default: result = raw;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX payload, waits for load data, hands results to WB.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.slave  bus
);

   logic            ms_valid;
   es_to_ms_t       ms_q;
   logic [XLEN-1:0] data_buf;
   dstate_e         state;
   dstate_e         state_nxt;
   logic            data_got;
   logic            ready_go;
   logic            allow_in;
   logic [XLEN-1:0] raw;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] final_result;

   // Stage occupancy and payload capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         ms_valid <= 1'b0;
         ms_q     <= '0;
      end else if (allow_in) begin
         ms_valid <= bus.es_to_ms_valid;
         if (bus.es_to_ms_valid) ms_q <= bus.es_to_ms_bus;
      end
   end

   // Data-wait state register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_WAIT;
      else     state <= state_nxt;
   end

   // Response arrived while WB is stalled: park it until hand-off.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_WAIT: if (bus.data_sram_data_ok && ms_valid && ms_q.res_from_mem
                      && !bus.ws_allow_in)
                     state_nxt = ST_HAVE;
         ST_HAVE: if (bus.ws_allow_in) state_nxt = ST_WAIT;
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_comb begin
      data_got = 1'b0;
      if (state == ST_HAVE) data_got = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         data_buf <= '0;
      else if (state == ST_WAIT && state_nxt == ST_HAVE)
         data_buf <= bus.data_sram_rdata;
   end

   assign ready_go = !ms_q.res_from_mem || data_got || bus.data_sram_data_ok;
   assign allow_in = !ms_valid || (ready_go && bus.ws_allow_in);
   assign raw      = data_got ? data_buf : bus.data_sram_rdata;

   mem_stage_load_align u_align (
      .raw       (raw),
      .addr      (ms_q.alu_result[1:0]),
      .load_type (ms_q.load_type),
      .result    (load_data)
   );

   assign final_result = ms_q.res_from_mem ? load_data : ms_q.alu_result;

   // Bubbles never write and never look like a pending load to ID.
   assign bus.ms_allow_in    = allow_in;
   assign bus.ms_to_ws_valid = ms_valid && ready_go;
   assign bus.ms_to_ws_bus   = '{rf_we:        ms_q.rf_we && ms_valid,
                                 dest:         ms_q.dest,
                                 pc:           ms_q.pc,
                                 final_result: final_result};
   assign bus.ms_to_che_bus  = '{load_pending: ms_valid && ms_q.res_from_mem && !ready_go,
                                 rf_we:        ms_q.rf_we && ms_valid,
                                 dest:         ms_q.dest};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads with/without WB stall, reset.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   mem_stage_if bus_if();

   mem_stage u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   function automatic es_to_ms_t mk_es(logic res, logic [2:0] lt, logic we,
                                       logic [4:0] d, logic [31:0] pc, logic [31:0] alu);
      es_to_ms_t e;
      e.res_from_mem = res;
      e.load_type    = load_type_e'(lt);
      e.rf_we        = we;
      e.dest         = d;
      e.pc           = pc;
      e.alu_result   = alu;
      return e;
   endfunction

   function automatic ms_to_ws_t mk_ws(logic we, logic [4:0] d, logic [31:0] pc, logic [31:0] r);
      ms_to_ws_t w;
      w.rf_we        = we;
      w.dest         = d;
      w.pc           = pc;
      w.final_result = r;
      return w;
   endfunction

   function automatic ms_to_che_t mk_che(logic p, logic we, logic [4:0] d);
      ms_to_che_t c;
      c.load_pending = p;
      c.rf_we        = we;
      c.dest         = d;
      return c;
   endfunction

   task automatic chk(string tag, logic [69:0] obs, logic [69:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks the three observable outputs together after inputs settle.
   task automatic chk_out(string tag, logic vld, logic alw, ms_to_ws_t w, ms_to_che_t c);
      #1;
      chk({tag, ".valid"}, 70'(bus_if.ms_to_ws_valid), 70'(vld));
      chk({tag, ".allow"}, 70'(bus_if.ms_allow_in), 70'(alw));
      if (vld) chk({tag, ".ws_bus"}, 70'(bus_if.ms_to_ws_bus), 70'(w));
      chk({tag, ".che"}, 70'(bus_if.ms_to_che_bus), 70'(c));
   endtask

   initial begin
      rst                       = 1'b1;
      bus_if.es_to_ms_valid     = 1'b0;
      bus_if.es_to_ms_bus       = '0;
      bus_if.ws_allow_in        = 1'b1;
      bus_if.data_sram_data_ok  = 1'b0;
      bus_if.data_sram_rdata    = 32'h0;

      // Reset held two cycles.
      tick();
      tick();
      #1;
      chk("rst.valid", 70'(bus_if.ms_to_ws_valid), 70'(1'b0));
      chk("rst.allow", 70'(bus_if.ms_allow_in), 70'(1'b1));
      chk("rst.che", 70'(bus_if.ms_to_che_bus), 70'(0));
      chk("rst.ws_bus", 70'(bus_if.ms_to_ws_bus), 70'(0));
      rst = 1'b0;

      // ALU op: one cycle in MEM.
      tick();
      bus_if.es_to_ms_valid = 1'b1;
      bus_if.es_to_ms_bus   = mk_es(1'b0, 3'd0, 1'b1, 5'd5, 32'h1c000000, 32'h12345678);
      tick();
      bus_if.es_to_ms_valid = 1'b0;
      chk_out("alu", 1'b1, 1'b1, mk_ws(1'b1, 5'd5, 32'h1c000000, 32'h12345678),
              mk_che(1'b0, 1'b1, 5'd5));
      tick();
      chk_out("alu.drain", 1'b0, 1'b1, '0, mk_che(1'b0, 1'b0, 5'd5));

      // ld.b at addr ..3, data_ok two cycles after entry.
      bus_if.es_to_ms_valid = 1'b1;
      bus_if.es_to_ms_bus   = mk_es(1'b1, 3'd1, 1'b1, 5'd6, 32'h1c000004, 32'h00001003);
      tick();
      bus_if.es_to_ms_valid = 1'b0;
      chk_out("ldb.wait0", 1'b0, 1'b0, '0, mk_che(1'b1, 1'b1, 5'd6));
      tick();
      chk_out("ldb.wait1", 1'b0, 1'b0, '0, mk_che(1'b1, 1'b1, 5'd6));
      tick();
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata   = 32'h80FF00AA;
      chk_out("ldb.ok", 1'b1, 1'b1, mk_ws(1'b1, 5'd6, 32'h1c000004, 32'hFFFFFF80),
              mk_che(1'b0, 1'b1, 5'd6));
      tick();
      bus_if.data_sram_data_ok = 1'b0;
      chk_out("ldb.drain", 1'b0, 1'b1, '0, mk_che(1'b0, 1'b0, 5'd6));

      // ld.hu at addr ..2, response while WB stalls for three cycles.
      bus_if.es_to_ms_valid = 1'b1;
      bus_if.es_to_ms_bus   = mk_es(1'b1, 3'd5, 1'b1, 5'd7, 32'h1c000008, 32'h00002002);
      tick();
      bus_if.es_to_ms_valid    = 1'b0;
      bus_if.ws_allow_in       = 1'b0;
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata   = 32'h80011234;
      chk_out("ldhu.ok", 1'b1, 1'b0, mk_ws(1'b1, 5'd7, 32'h1c000008, 32'h00008001),
              mk_che(1'b0, 1'b1, 5'd7));
      tick();
      bus_if.data_sram_data_ok = 1'b0;
      bus_if.data_sram_rdata   = 32'hDEADBEEF;
      chk_out("ldhu.buf1", 1'b1, 1'b0, mk_ws(1'b1, 5'd7, 32'h1c000008, 32'h00008001),
              mk_che(1'b0, 1'b1, 5'd7));
      tick();
      chk_out("ldhu.buf2", 1'b1, 1'b0, mk_ws(1'b1, 5'd7, 32'h1c000008, 32'h00008001),
              mk_che(1'b0, 1'b1, 5'd7));
      tick();
      bus_if.ws_allow_in    = 1'b1;
      bus_if.es_to_ms_valid = 1'b1;
      bus_if.es_to_ms_bus   = mk_es(1'b0, 3'd0, 1'b1, 5'd8, 32'h1c00000c, 32'hCAFEF00D);
      chk_out("ldhu.handoff", 1'b1, 1'b1, mk_ws(1'b1, 5'd7, 32'h1c000008, 32'h00008001),
              mk_che(1'b0, 1'b1, 5'd7));
      tick();
      bus_if.es_to_ms_valid = 1'b0;
      bus_if.data_sram_rdata = 32'h0;
      chk_out("ldhu.next", 1'b1, 1'b1, mk_ws(1'b1, 5'd8, 32'h1c00000c, 32'hCAFEF00D),
              mk_che(1'b0, 1'b1, 5'd8));
      tick();

      // Back-to-back ALU, lw, ALU with continuous valid.
      bus_if.es_to_ms_valid = 1'b1;
      bus_if.es_to_ms_bus   = mk_es(1'b0, 3'd0, 1'b1, 5'd9, 32'h1c000010, 32'h00000111);
      tick();
      bus_if.es_to_ms_bus   = mk_es(1'b1, 3'd0, 1'b1, 5'd10, 32'h1c000014, 32'h00000004);
      chk_out("b2b.alu1", 1'b1, 1'b1, mk_ws(1'b1, 5'd9, 32'h1c000010, 32'h00000111),
              mk_che(1'b0, 1'b1, 5'd9));
      tick();
      bus_if.es_to_ms_bus   = mk_es(1'b0, 3'd0, 1'b1, 5'd11, 32'h1c000018, 32'h00000333);
      chk_out("b2b.ldwait0", 1'b0, 1'b0, '0, mk_che(1'b1, 1'b1, 5'd10));
      tick();
      chk_out("b2b.ldwait1", 1'b0, 1'b0, '0, mk_che(1'b1, 1'b1, 5'd10));
      tick();
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata   = 32'h55AA55AA;
      chk_out("b2b.ld", 1'b1, 1'b1, mk_ws(1'b1, 5'd10, 32'h1c000014, 32'h55AA55AA),
              mk_che(1'b0, 1'b1, 5'd10));
      tick();
      bus_if.data_sram_data_ok = 1'b0;
      bus_if.es_to_ms_valid    = 1'b0;
      chk_out("b2b.alu2", 1'b1, 1'b1, mk_ws(1'b1, 5'd11, 32'h1c000018, 32'h00000333),
              mk_che(1'b0, 1'b1, 5'd11));
      tick();
      chk_out("b2b.drain", 1'b0, 1'b1, '0, mk_che(1'b0, 1'b0, 5'd11));

      // Reset while a load is pending.
      bus_if.es_to_ms_valid = 1'b1;
      bus_if.es_to_ms_bus   = mk_es(1'b1, 3'd0, 1'b1, 5'd12, 32'h1c00001c, 32'h00000008);
      tick();
      bus_if.es_to_ms_valid = 1'b0;
      chk_out("rstld.wait", 1'b0, 1'b0, '0, mk_che(1'b1, 1'b1, 5'd12));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_out("rstld.clear", 1'b0, 1'b1, '0, mk_che(1'b0, 1'b0, 5'd0));
      chk("rstld.ws_bus", 70'(bus_if.ms_to_ws_bus), 70'(0));
      tick();
      chk_out("rstld.idle", 1'b0, 1'b1, '0, mk_che(1'b0, 1'b0, 5'd0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
